// File: rtl/digest_writeback_if.sv
// Digest handoff and shared memory write bus for the writeback stage.
// The hash stage drives the digest side; this block drives the memory side.
interface digest_writeback_if #(
  parameter int ADDR_W = 16
) ();
  logic              digest_valid;
  logic              digest_ready;
  logic [255:0]      digest;
  logic [ADDR_W-1:0] output_addr;
  logic [8:0]        zero_bits;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;

  modport master (
    output digest_valid, digest, output_addr, zero_bits,
    input  digest_ready, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    input  digest_valid, digest, output_addr, zero_bits,
    output digest_ready, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/digest_writeback.sv
// Writes a 256-bit SHA-256 digest word by word to memory and pulses done.
// Define DIGEST_TARGET_CHECK_EN to add the leading-zero check and status word.
module digest_writeback #(
  parameter int ADDR_W    = 16,
  parameter int NUM_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  digest_writeback_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              hit
);
  localparam int CNT_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, STATUS, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [255:0]       dig_r;
  logic [31:0]        word_nxt;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [31:0]        mem_data_r;
  logic               mem_we_r;

  assign cnt_nxt  = CNT_W'(cnt + 1'b1);
  // Word k sits at the top after shifting left by 32*k.
  assign word_nxt = 32'((dig_r << {cnt_nxt, 5'b0}) >> 224);

  assign bus.digest_ready   = (state == IDLE);
  assign bus.mem_we         = mem_we_r;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.mem_write_data = mem_data_r;
  assign busy               = (state != IDLE);

`ifdef DIGEST_TARGET_CHECK_EN
  logic [8:0] zb_r;
  logic [8:0] lz;
  logic       hit_c;
  logic       hit_r;

  // Ascending scan: the highest set bit is the last to assign.
  always_comb begin
    lz = 9'd256;
    for (int i = 0; i < 256; i++)
      if (dig_r[i]) lz = 9'(255 - i);
  end

  assign hit_c = (lz >= zb_r);
  assign hit   = hit_r;
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dig_r      <= '0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
      done       <= 1'b0;
`ifdef DIGEST_TARGET_CHECK_EN
      zb_r       <= '0;
      hit_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.digest_valid) begin
            dig_r      <= bus.digest;
            cnt        <= '0;
            mem_we_r   <= 1'b1;
            mem_addr_r <= bus.output_addr;
            mem_data_r <= bus.digest[255:224];
            state      <= WRITE;
`ifdef DIGEST_TARGET_CHECK_EN
            zb_r  <= (bus.zero_bits > 9'd256) ? 9'd256 : bus.zero_bits;
            hit_r <= 1'b0;
`endif
          end
        end
        WRITE: begin
          if (cnt == CNT_W'(NUM_WORDS - 1)) begin
`ifdef DIGEST_TARGET_CHECK_EN
            mem_addr_r <= mem_addr_r + 1'b1;
            mem_data_r <= {hit_c, 22'b0, lz};
            state      <= STATUS;
`else
            mem_we_r   <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
`endif
          end else begin
            cnt        <= cnt_nxt;
            mem_addr_r <= mem_addr_r + 1'b1;
            mem_data_r <= word_nxt;
          end
        end
        STATUS: begin
`ifdef DIGEST_TARGET_CHECK_EN
          hit_r <= hit_c;
`endif
          mem_we_r <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digest_writeback.sv
// Self-checking bench for digest_writeback: directed plus random digests
// checked cycle by cycle against a behavioural model of the write sequence.
module tb_digest_writeback;
`ifdef DIGEST_TARGET_CHECK_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 10;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic busy, done, hit;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  digest_writeback_if #(.ADDR_W(16)) bus ();

  digest_writeback #(.ADDR_W(16), .NUM_WORDS(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .busy   (busy),
    .done   (done),
    .hit    (hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_lz(input logic [255:0] d);
    int n = 0;
    while (n < 256 && d[255 - n] === 1'b0) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_word(input logic [255:0] d, input int k);
    logic [255:0] s;
    s = d >> (32 * (7 - k));
    return s[31:0];
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d = {d[223:0], 32'($urandom)};
    return d;
  endfunction

  // Presents one digest, then follows the whole write sequence cycle by cycle.
  task automatic run_one(input logic [255:0] d, input logic [15:0] base,
                         input logic [8:0] zb, input bit hold_valid, output int t0);
    int  lz, zbe;
    bit  hx;
    logic [15:0] a;
    lz  = model_lz(d);
    zbe = (int'(zb) > 256) ? 256 : int'(zb);
    hx  = (lz >= zbe);
`ifndef DIGEST_TARGET_CHECK_EN
    hx  = 1'b0;
`endif
    bus.digest_valid = 1'b1;
    bus.digest       = d;
    bus.output_addr  = base;
    bus.zero_bits    = zb;
    chk("ready_idle", bus.digest_ready, 1);
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(k);
      chk("ready_busy", bus.digest_ready, 0);
      chk("busy_write", busy, 1);
      chk("we_write", bus.mem_we, 1);
      chk("addr_word", bus.mem_addr, a);
      chk("data_word", bus.mem_write_data, model_word(d, k));
      chk("done_write", done, 0);
      chk("hit_cleared", hit, 0);
      // Later inputs must not disturb the captured result.
      bus.digest       = rand_digest();
      bus.output_addr  = 16'($urandom);
      bus.zero_bits    = 9'($urandom);
      bus.digest_valid = hold_valid;
      @(posedge clk); #1;
    end
`ifdef DIGEST_TARGET_CHECK_EN
    a = base + 16'd8;
    chk("we_status", bus.mem_we, 1);
    chk("addr_status", bus.mem_addr, a);
    chk("data_status", bus.mem_write_data, (hx ? 32'h8000_0000 : 32'h0) | 32'(lz));
    chk("done_status", done, 0);
    @(posedge clk); #1;
`endif
    chk("done_pulse", done, 1);
    chk("we_done", bus.mem_we, 0);
    chk("ready_done", bus.digest_ready, 0);
    chk("busy_done", busy, 1);
    chk("hit_result", hit, hx);
    @(posedge clk); #1;
    chk("done_once", done, 0);
    chk("ready_back", bus.digest_ready, 1);
    chk("busy_back", busy, 0);
    chk("hit_hold", hit, hx);
  endtask

  initial begin
    logic [255:0] dplan, d;
    int t0a, t0b, tr;

    reset_n          = 1'b0;
    bus.digest_valid = 1'b0;
    bus.digest       = '0;
    bus.output_addr  = '0;
    bus.zero_bits    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.digest_ready, 1);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_data", bus.mem_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    dplan = {32'h0, 32'h0FFF_FFFF, {6{32'hFFFF_FFFF}}};
    run_one(dplan, 16'h0100, 9'd36, 1'b0, t0a);
    run_one(dplan, 16'h0100, 9'd37, 1'b0, t0a);
    run_one('0, 16'h0200, 9'd256, 1'b0, t0a);
    run_one('0, 16'h0300, 9'd300, 1'b0, t0a);
    run_one(rand_digest(), 16'h0400, 9'd0, 1'b0, t0a);
    run_one(rand_digest(), 16'hFFFC, 9'd1, 1'b0, t0a);

    // Back-to-back accepts with digest_valid never dropping.
    run_one(rand_digest(), 16'h1000, 9'd4, 1'b1, t0a);
    run_one(rand_digest(), 16'h2000, 9'd4, 1'b1, t0b);
    chk("accept_spacing", 32'(t0b - t0a), 32'(PERIOD));
    bus.digest_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a write abandons the result.
    bus.digest_valid = 1'b1;
    bus.digest       = rand_digest();
    bus.output_addr  = 16'h0500;
    bus.zero_bits    = 9'd0;
    @(posedge clk); #1;
    tr = cyc;
    bus.digest_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_at_t4", 32'(cyc - tr), 4);
    chk("midrst_we_pre", bus.mem_we, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_we", bus.mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_hit", hit, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_nodone", done, 0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_nodone_after", done, 0);
    run_one(rand_digest(), 16'h0600, 9'd8, 1'b0, t0a);

    // Random digests with a random run of leading zeros and random targets.
    for (int i = 0; i < 8; i++) begin
      d = rand_digest() >> $urandom_range(0, 40);
      run_one(d, 16'($urandom), 9'($urandom_range(0, 300)), 1'($urandom_range(0, 1)), t0a);
    end
    bus.digest_valid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
